fib_stream_checker_fifo: RTL and testbench
==========================================

Name: fib_stream_checker_fifo

Overview:
Downstream consumer of the 32-bit Fibonacci generator output. Each accepted term is tagged with its term index, a sequence-error flag (term != sum of the previous two) and a 32-bit wrap flag (modular overflow). Tagged terms are buffered in a first-word-fall-through FIFO with a valid/ready output toward the host or readout logic. Overflowing input is dropped and counted.

Parameters:
DATA_W, 32, term width; must match generator output width.
DEPTH, 8, FIFO entries; power of two, >= 2.
INDEX_W, 8, term-index width; saturates at all-ones.
DROP_W, 16, drop-counter width; saturates at all-ones.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
clear  in  1  synchronous clear of FIFO, checker and counters.
in_valid  in  1  in_data holds a new term this cycle.
in_data  in  DATA_W  term from generator.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  consumer accepts head entry.
out_data  out  DATA_W  head term.
out_index  out  INDEX_W  head term index (0-based).
out_err  out  1  head term failed recurrence check.
out_wrap  out  1  head term is a 32-bit wrap.
full  out  1  level == DEPTH.
level  out  clog2(DEPTH)+1  entries held.
drop_count  out  DROP_W  terms dropped while full.

Behaviour:
- Reset (rst high, async) and clear (sync, priority over all other inputs): FIFO empty, out_valid=0, full=0, level=0, drop_count=0, checker state S_EMPTY, index=0, prev1=prev2=0. out_data/out_index/out_err/out_wrap are 0 when empty.
- Checker FSM advances only on in_valid:
  - S_EMPTY: term tagged index 0; err = (in_data != 0); wrap=0; prev1<=in_data; go S_ONE.
  - S_ONE: index 1; err = (in_data != 1); wrap=0; prev2<=prev1, prev1<=in_data; go S_RUN.
  - S_RUN: expected = prev1 + prev2, truncated to DATA_W. err = (in_data != expected). wrap = (in_data < prev1), unsigned compare. Shift history with the received value, not the expected one, so checking resynchronises after a single corrupted term. Remain in S_RUN.
- Index increments per accepted-or-dropped term; saturates at 2^INDEX_W-1 and does not wrap. The checker advances even when the term is dropped, so the history stays aligned with the generator.
- Push: in_valid && (!full || pop). Pop: out_valid && out_ready. Simultaneous push and pop at full: both occur, level unchanged, no drop. Pop while empty is ignored.
- Drop: in_valid && full && !pop. drop_count increments, saturating at all-ones.
- Latency: a term accepted at edge N appears on out_* after edge N (first-word-fall-through), i.e. visible in cycle N+1 when the FIFO was empty. The head is read combinationally from the storage array.
- level/full update on the same edge as push/pop. Pointers wrap modulo DEPTH.
- rst asserted mid-stream: all state is lost immediately. The next term is treated as index 0.

Decomposition:
- Package fib_pkg: DATA_W default constant; fib_entry_t struct {data, index, err, wrap}; checker state enum {S_EMPTY, S_ONE, S_RUN}.
- Sub-module fib_sync_fifo: generic FWFT FIFO of fib_entry_t with push/pop, level, full, empty. The top level holds the checker FSM, the drop logic and the counters.

Test Plan:
- Reset: rst pulse with in_valid=1 -> out_valid=0, level=0, drop_count=0; the first term after release is tagged index 0.
- Nominal: drive a generator-connected stream 0,1,1,2,3,5 with out_ready=1 -> six entries, index 0..5, err=0, wrap=0, each appearing one cycle after its input.
- Wrap: run 49 terms with out_ready=1 -> index 47 data 2971215073 wrap=0; index 48 data 512559680 wrap=1, err=0.
- Corruption: inject 0,1,1,5,6,11 -> err=1 only at index 3; index 4 (6=5+1) and index 5 (11=6+5) have err=0, showing resync.
- Full/drop: DEPTH=4, out_ready=0, push 6 terms -> full=1, level=4, drop_count=2; next drained term is index 0. With full=1, assert in_valid and out_ready together -> level stays 4, drop_count unchanged.
- Clear mid-stream: clear=1 while level=3 -> next cycle level=0, out_valid=0, drop_count=0; the next input is tagged index 0 and checked against 0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci stream checker:
// tagged-entry layout and checker state encoding.
package fib_pkg;

  localparam int FIB_DATA_W  = 32;
  localparam int FIB_INDEX_W = 8;

  typedef struct packed {
    logic [FIB_DATA_W-1:0]  data;
    logic [FIB_INDEX_W-1:0] index;
    logic                   err;
    logic                   wrap;
  } fib_entry_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_RUN
  } chk_state_t;

endpackage

// File: rtl/fib_sync_fifo.sv
// First-word-fall-through FIFO; the head is read
// straight from storage and forced to zero when empty.
module fib_sync_fifo
  import fib_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = fib_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_pop;
  logic          do_push;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == LW'(DEPTH));
  assign level_o = lvl_q;
  assign data_o  = empty_o ? T'('0) : mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop) rd_d = rd_q + 1'b1;
    if (do_push && !do_pop) lvl_d = lvl_q + 1'b1;
    if (do_pop && !do_push) lvl_d = lvl_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fib_stream_checker_fifo.sv
// Tags each generator term with index, recurrence error
// and wrap flag, then buffers it; overflow is dropped.
module fib_stream_checker_fifo
  import fib_pkg::*;
#(
  parameter int  DATA_W  = FIB_DATA_W,
  parameter int  DEPTH   = 8,
  parameter int  INDEX_W = FIB_INDEX_W,
  parameter int  DROP_W  = 16,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [INDEX_W-1:0] out_index,
  output logic               out_err,
  output logic               out_wrap,
  output logic               full,
  output logic [LW-1:0]      level,
  output logic [DROP_W-1:0]  drop_count
);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [INDEX_W-1:0] index;
    logic               err;
    logic               wrap;
  } entry_t;

  chk_state_t         state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]  prev1_q, prev1_d;
  logic [DATA_W-1:0]  prev2_q, prev2_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [DATA_W-1:0]  expected;
  entry_t             tag;
  entry_t             head;
  logic               empty;
  logic               pop;
  logic               push;
  logic               drop;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  assign expected = prev1_q + prev2_q;

  always_comb begin
    tag       = '0;
    tag.data  = in_data;
    tag.index = idx_q;
    state_d   = state_q;
    prev1_d   = prev1_q;
    prev2_d   = prev2_q;
    idx_d     = idx_q;
    drop_d    = drop_q;
    unique case (state_q)
      S_EMPTY: begin
        tag.err = (in_data != '0);
        state_d = S_ONE;
      end
      S_ONE: begin
        tag.err = (in_data != DATA_W'(1));
        state_d = S_RUN;
        prev2_d = prev1_q;
      end
      S_RUN: begin
        tag.err  = (in_data != expected);
        tag.wrap = (in_data < prev1_q);
        prev2_d  = prev1_q;
      end
      default: state_d = S_EMPTY;
    endcase
    // history follows the received term so one bad term resyncs
    prev1_d = in_data;
    if (idx_q != '1) idx_d = idx_q + 1'b1;
    if (drop && drop_q != '1) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
      drop_q  <= '0;
    end else if (clear) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
      drop_q  <= '0;
    end else if (in_valid) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      prev1_q <= prev1_d;
      prev2_q <= prev2_d;
      drop_q  <= drop_d;
    end
  end

  fib_sync_fifo #(
    .DEPTH(DEPTH),
    .T    (entry_t)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clear_i(clear),
    .push_i (push),
    .data_i (tag),
    .pop_i  (pop),
    .data_o (head),
    .level_o(level),
    .full_o (full),
    .empty_o(empty)
  );

  assign out_valid  = !empty;
  assign out_data   = head.data;
  assign out_index  = head.index;
  assign out_err    = head.err;
  assign out_wrap   = head.wrap;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fib_stream_checker_fifo.sv
// Directed bench for the Fibonacci stream checker with
// a queue-based reference model checked every cycle.
module tb_fib_stream_checker_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [7:0]  out_index;
  logic        out_err;
  logic        out_wrap;
  logic        full;
  logic [LW-1:0] level;
  logic [15:0] drop_count;

  fib_stream_checker_fifo #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .INDEX_W(8),
    .DROP_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_err   (out_err),
    .out_wrap  (out_wrap),
    .full      (full),
    .level     (level),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          idx;
    bit          e;
    bit          w;
  } ent_t;

  ent_t        mq[$];
  ent_t        dlog[$];
  int          n;
  logic [31:0] p1, p2;
  int          drops;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] fib [64];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    n = 0;
    p1 = '0;
    p2 = '0;
    drops = 0;
  endtask

  // spec rules: index = terms seen, err vs recurrence, wrap = sum < prev
  task automatic model_step();
    bit   pop, isfull, push, drp;
    ent_t t;
    if (clear) begin
      model_reset();
      return;
    end
    isfull = (mq.size() == DEPTH);
    pop    = (mq.size() != 0) && out_ready;
    push   = in_valid && (!isfull || pop);
    drp    = in_valid && isfull && !pop;
    t = '{d: in_data, idx: (n > 255) ? 255 : n, e: 1'b0, w: 1'b0};
    if (in_valid) begin
      if (n == 0) t.e = (in_data != 0);
      else if (n == 1) t.e = (in_data != 1);
      else begin
        t.e = (in_data != 32'(p1 + p2));
        t.w = (in_data < p1);
      end
      n++;
      p2 = p1;
      p1 = in_data;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(t);
    if (drp && drops < 65535) drops++;
  endtask

  task automatic compare_all();
    ent_t h;
    h = '{d: 0, idx: 0, e: 0, w: 0};
    if (mq.size() != 0) h = mq[0];
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("level", 64'(level), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("drop_count", 64'(drop_count), 64'(drops));
    chk("out_data", 64'(out_data), 64'(h.d));
    chk("out_index", 64'(out_index), 64'(h.idx));
    chk("out_err", 64'(out_err), 64'(h.e));
    chk("out_wrap", 64'(out_wrap), 64'(h.w));
  endtask

  task automatic cycle();
    if (out_valid && out_ready)
      dlog.push_back('{d: out_data, idx: int'(out_index),
                       e: out_err, w: out_wrap});
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic put(input logic [31:0] d, input bit v, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    cycle();
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b0;
    cycle();
    clear = 1'b0;
    dlog.delete();
  endtask

  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];

    // reset held with in_valid high
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;
    put(32'd0, 1, 0);
    chk("rst_first_idx", 64'(out_index), 64'd0);
    chk("rst_first_err", 64'(out_err), 64'd0);

    // nominal stream
    do_clear();
    for (int i = 0; i < 6; i++) put(fib[i], 1, 1);
    put(0, 0, 1);
    chk("nom_count", 64'(dlog.size()), 64'd6);
    for (int i = 0; i < 6 && i < dlog.size(); i++) begin
      chk("nom_idx", 64'(dlog[i].idx), 64'(i));
      chk("nom_data", 64'(dlog[i].d), 64'(fib[i]));
      chk("nom_err", 64'(dlog[i].e), 64'd0);
    end

    // corrupted term then resync
    do_clear();
    begin
      logic [31:0] cv [6];
      bit          ce [6];
      cv = '{0, 1, 1, 5, 6, 11};
      ce = '{0, 0, 0, 1, 0, 0};
      for (int i = 0; i < 6; i++) put(cv[i], 1, 1);
      put(0, 0, 1);
      chk("cor_count", 64'(dlog.size()), 64'd6);
      for (int i = 0; i < 6 && i < dlog.size(); i++)
        chk("cor_err", 64'(dlog[i].e), 64'(ce[i]));
    end

    // 32-bit wrap at index 48
    do_clear();
    for (int i = 0; i < 49; i++) put(fib[i], 1, 1);
    put(0, 0, 1);
    chk("wrap_count", 64'(dlog.size()), 64'd49);
    if (dlog.size() == 49) begin
      chk("wrap47_data", 64'(dlog[47].d), 64'd2971215073);
      chk("wrap47_wrap", 64'(dlog[47].w), 64'd0);
      chk("wrap48_idx", 64'(dlog[48].idx), 64'd48);
      chk("wrap48_data", 64'(dlog[48].d), 64'd512559680);
      chk("wrap48_wrap", 64'(dlog[48].w), 64'd1);
      chk("wrap48_err", 64'(dlog[48].e), 64'd0);
    end

    // full and drop
    do_clear();
    for (int i = 0; i < 6; i++) put(fib[i], 1, 0);
    chk("fd_full", 64'(full), 64'd1);
    chk("fd_level", 64'(level), 64'd4);
    chk("fd_drops", 64'(drop_count), 64'd2);
    put(32'd8, 1, 1);
    chk("fd_pp_level", 64'(level), 64'd4);
    chk("fd_pp_drops", 64'(drop_count), 64'd2);
    for (int i = 0; i < 5; i++) put(0, 0, 1);
    chk("fd_count", 64'(dlog.size()), 64'd5);
    if (dlog.size() == 5) begin
      chk("fd_first_idx", 64'(dlog[0].idx), 64'd0);
      chk("fd_last_idx", 64'(dlog[4].idx), 64'd6);
      chk("fd_last_err", 64'(dlog[4].e), 64'd0);
    end

    // clear mid-stream, drops still pending from above
    for (int i = 0; i < 3; i++) put(32'd100 + i, 1, 0);
    chk("clr_pre_level", 64'(level), 64'd3);
    do_clear();
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_drops", 64'(drop_count), 64'd0);
    put(32'd0, 1, 0);
    chk("clr_idx", 64'(out_index), 64'd0);
    chk("clr_err", 64'(out_err), 64'd0);

    // async reset mid-stream
    put(32'd1, 1, 0);
    put(32'd1, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    rst = 1'b0;
    put(32'd7, 1, 0);
    chk("rst_mid_idx", 64'(out_index), 64'd0);
    chk("rst_mid_err", 64'(out_err), 64'd1);
    put(0, 0, 1);
    put(0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
